// File: rtl/mips_wb_port_arbiter_if.sv
// Register-file write-port arbitration bundle: pipeline WB, MDU result
// handshake, register-file write port and ID-stage pending lookups.
`ifndef MIPS_RFIDX_WIDTH
`define MIPS_RFIDX_WIDTH 5
`endif
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif

interface mips_wb_port_arbiter_if;
    logic                         wb_en;
    logic [`MIPS_RFIDX_WIDTH-1:0] wb_idx;
    logic [`MIPS_DATA_WIDTH-1:0]  wb_dat;
    logic                         mdu_valid;
    logic                         mdu_ready;
    logic [`MIPS_RFIDX_WIDTH-1:0] mdu_idx;
    logic [`MIPS_DATA_WIDTH-1:0]  mdu_dat;
    logic                         rf_wen;
    logic [`MIPS_RFIDX_WIDTH-1:0] rf_widx;
    logic [`MIPS_DATA_WIDTH-1:0]  rf_wdat;
    logic [`MIPS_RFIDX_WIDTH-1:0] rs_idx;
    logic [`MIPS_RFIDX_WIDTH-1:0] rt_idx;
    logic                         rs_pend;
    logic                         rt_pend;
    logic                         stall_req;

    modport slave (
        input  wb_en, wb_idx, wb_dat,
        input  mdu_valid, mdu_idx, mdu_dat,
        input  rs_idx, rt_idx,
        output mdu_ready,
        output rf_wen, rf_widx, rf_wdat,
        output rs_pend, rt_pend, stall_req
    );

    modport master (
        output wb_en, wb_idx, wb_dat,
        output mdu_valid, mdu_idx, mdu_dat,
        output rs_idx, rt_idx,
        input  mdu_ready,
        input  rf_wen, rf_widx, rf_wdat,
        input  rs_pend, rt_pend, stall_req
    );
endinterface

// File: rtl/mips_wb_port_arbiter.sv
// Shares the register-file write port between pipeline WB (priority) and
// buffered MDU results, with kill-on-overwrite ordering and starvation stall.
`ifndef MIPS_RFIDX_WIDTH
`define MIPS_RFIDX_WIDTH 5
`endif
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif

module mips_wb_port_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                   clk,
    input logic                   rst,
    mips_wb_port_arbiter_if.slave bus
);
    localparam int RW = `MIPS_RFIDX_WIDTH;
    localparam int DW = `MIPS_DATA_WIDTH;
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic          vld;
        logic [RW-1:0] idx;
        logic [DW-1:0] dat;
        logic          kill;
    } entry_t;

    entry_t        q     [FIFO_DEPTH];
    entry_t        q_nxt [FIFO_DEPTH];
    entry_t        sh    [FIFO_DEPTH+1];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic wb_win;
    logic nonempty;
    logic full;
    logic pop;
    logic push;
    logic placed;

    assign wb_win   = bus.wb_en && (bus.wb_idx != '0);
    assign nonempty = q[0].vld;
    assign full     = q[FIFO_DEPTH-1].vld;
    assign pop      = !wb_win && nonempty;
    assign push     = bus.mdu_valid && bus.mdu_ready && (bus.mdu_idx != '0);

    // Shift-register FIFO: head lives in slot 0, pops shift everything down.
    always_comb begin
        placed = 1'b0;
        sh[FIFO_DEPTH] = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            sh[i] = q[i];
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            q_nxt[i] = pop ? sh[i+1] : sh[i];
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push && !placed && !q_nxt[i].vld) begin
                q_nxt[i].vld  = 1'b1;
                q_nxt[i].idx  = bus.mdu_idx;
                q_nxt[i].dat  = bus.mdu_dat;
                q_nxt[i].kill = 1'b0;
                placed        = 1'b1;
            end
        end
        // A WB write to the same register makes older MDU values obsolete.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wb_win && q_nxt[i].vld && (q_nxt[i].idx == bus.wb_idx)) begin
                q_nxt[i].kill = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        if (nonempty && !pop) begin
            cnt_nxt = (cnt == CW'(STARVE_MAX)) ? cnt : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q[i] <= '0;
            end
            cnt <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q[i] <= q_nxt[i];
            end
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        bus.rf_wen  = 1'b0;
        bus.rf_widx = '0;
        bus.rf_wdat = '0;
        if (!rst) begin
            if (wb_win) begin
                bus.rf_wen  = 1'b1;
                bus.rf_widx = bus.wb_idx;
                bus.rf_wdat = bus.wb_dat;
            end else if (nonempty) begin
                bus.rf_wen  = !q[0].kill;
                bus.rf_widx = q[0].idx;
                bus.rf_wdat = q[0].dat;
            end
        end
    end

    always_comb begin
        bus.rs_pend = 1'b0;
        bus.rt_pend = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (q[i].vld && !q[i].kill) begin
                if (bus.rs_idx != '0 && q[i].idx == bus.rs_idx) begin
                    bus.rs_pend = 1'b1;
                end
                if (bus.rt_idx != '0 && q[i].idx == bus.rt_idx) begin
                    bus.rt_pend = 1'b1;
                end
            end
        end
        if (rst) begin
            bus.rs_pend = 1'b0;
            bus.rt_pend = 1'b0;
        end
    end

    assign bus.mdu_ready = !rst && !full;
    assign bus.stall_req = !rst && (cnt == CW'(STARVE_MAX));

endmodule

// File: tb/tb_mips_wb_port_arbiter.sv
// Directed bench for mips_wb_port_arbiter: expected register-file writes go
// through an in-order scoreboard; handshake/pending/stall checked inline.
module tb_mips_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] dat;
    } wr_t;

    wr_t sb[$];

    mips_wb_port_arbiter_if bus();

    mips_wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every observed rf write must be the next expected one.
    always @(negedge clk) begin
        if (!rst && bus.rf_wen === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {27'd0, bus.rf_widx}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_idx", {27'd0, bus.rf_widx}, {27'd0, e.idx});
                check("wr_dat", bus.rf_wdat, e.dat);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wb(input logic [4:0] i, input logic [31:0] d);
        bus.wb_en  = 1'b1;
        bus.wb_idx = i;
        bus.wb_dat = d;
        sb.push_back({i, d});
    endtask

    task automatic wb_off();
        bus.wb_en  = 1'b0;
        bus.wb_idx = '0;
        bus.wb_dat = '0;
    endtask

    task automatic mdu(input logic v, input logic [4:0] i, input logic [31:0] d);
        bus.mdu_valid = v;
        bus.mdu_idx   = i;
        bus.mdu_dat   = d;
    endtask

    initial begin
        bus.wb_en = 1'b1; bus.wb_idx = 5'd5; bus.wb_dat = 32'h55;
        mdu(1'b0, '0, '0);
        bus.rs_idx = '0;
        bus.rt_idx = '0;

        smp();
        check("rst_rf_wen", {31'd0, bus.rf_wen}, 32'd0);
        check("rst_ready", {31'd0, bus.mdu_ready}, 32'd0);
        check("rst_stall", {31'd0, bus.stall_req}, 32'd0);
        cyc();
        rst = 1'b0;
        wb_off();

        // 1: idle accept, written the next cycle
        mdu(1'b1, 5'd5, 32'hA);
        bus.rs_idx = 5'd5;
        smp();
        check("t1_ready", {31'd0, bus.mdu_ready}, 32'd1);
        check("t1_no_bypass", {31'd0, bus.rf_wen}, 32'd0);
        check("t1_pend0", {31'd0, bus.rs_pend}, 32'd0);
        sb.push_back({5'd5, 32'hA});
        cyc();
        mdu(1'b0, '0, '0);
        smp();
        check("t1_pend_c1", {31'd0, bus.rs_pend}, 32'd1);
        cyc();
        smp();
        check("t1_pend_c2", {31'd0, bus.rs_pend}, 32'd0);
        check("t1_idle", {31'd0, bus.rf_wen}, 32'd0);
        cyc();

        // 2: WB overwrite kills the buffered MDU result
        mdu(1'b1, 5'd3, 32'h33);
        wb(5'd7, 32'h77);
        bus.rs_idx = 5'd3;
        cyc();
        mdu(1'b0, '0, '0);
        wb(5'd3, 32'h1);
        smp();
        check("t2_pend_live", {31'd0, bus.rs_pend}, 32'd1);
        cyc();
        wb_off();
        smp();
        check("t2_killed_pop", {31'd0, bus.rf_wen}, 32'd0);
        check("t2_pend_killed", {31'd0, bus.rs_pend}, 32'd0);
        cyc();
        smp();
        check("t2_after", {31'd0, bus.rf_wen}, 32'd0);
        cyc();

        // 3: fill the FIFO under continuous WB, drain in order
        wb(5'd8, 32'h80);
        mdu(1'b1, 5'd11, 32'hB1);
        cyc();
        wb(5'd9, 32'h90);
        mdu(1'b1, 5'd12, 32'hB2);
        smp();
        check("t3_ready_c2", {31'd0, bus.mdu_ready}, 32'd1);
        cyc();
        wb(5'd10, 32'hA0);
        mdu(1'b1, 5'd13, 32'hB3);
        bus.rt_idx = 5'd12;
        smp();
        check("t3_full", {31'd0, bus.mdu_ready}, 32'd0);
        check("t3_rt_pend", {31'd0, bus.rt_pend}, 32'd1);
        cyc();
        wb_off();
        sb.push_back({5'd11, 32'hB1});
        sb.push_back({5'd12, 32'hB2});
        sb.push_back({5'd13, 32'hB3});
        smp();
        check("t3_full_pop", {31'd0, bus.mdu_ready}, 32'd0);
        cyc();
        smp();
        check("t3_ready_again", {31'd0, bus.mdu_ready}, 32'd1);
        cyc();
        mdu(1'b0, '0, '0);
        cyc();
        smp();
        check("t3_drained", {31'd0, bus.rf_wen}, 32'd0);
        check("t3_ready_end", {31'd0, bus.mdu_ready}, 32'd1);
        check("t3_rt_clear", {31'd0, bus.rt_pend}, 32'd0);
        bus.rt_idx = '0;
        cyc();

        // 4: starvation counter reaches STARVE_MAX
        mdu(1'b1, 5'd14, 32'hC);
        wb(5'd15, 32'hF0);
        cyc();
        mdu(1'b0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            wb(5'(16 + k), 32'h100 + 32'(k));
            smp();
            check("t4_no_stall", {31'd0, bus.stall_req}, 32'd0);
            cyc();
        end
        wb_off();
        sb.push_back({5'd14, 32'hC});
        smp();
        check("t4_stall", {31'd0, bus.stall_req}, 32'd1);
        cyc();
        smp();
        check("t4_stall_clr", {31'd0, bus.stall_req}, 32'd0);
        cyc();

        // 5: idx 0 MDU result and idx 0 WB are both no-ops
        mdu(1'b1, 5'd0, 32'h5);
        bus.wb_en = 1'b1; bus.wb_idx = 5'd0; bus.wb_dat = 32'hDEAD;
        bus.rs_idx = 5'd0;
        smp();
        check("t5_ready", {31'd0, bus.mdu_ready}, 32'd1);
        check("t5_wb0", {31'd0, bus.rf_wen}, 32'd0);
        cyc();
        mdu(1'b0, '0, '0);
        wb_off();
        smp();
        check("t5_no_write", {31'd0, bus.rf_wen}, 32'd0);
        check("t5_no_pend", {31'd0, bus.rs_pend}, 32'd0);
        check("t5_no_stall", {31'd0, bus.stall_req}, 32'd0);
        cyc();

        // 6: reset discards buffered results
        wb(5'd22, 32'h220);
        mdu(1'b1, 5'd20, 32'h200);
        cyc();
        wb(5'd23, 32'h230);
        mdu(1'b1, 5'd21, 32'h210);
        cyc();
        mdu(1'b0, '0, '0);
        wb(5'd24, 32'h240);
        bus.rs_idx = 5'd20;
        bus.rt_idx = 5'd21;
        smp();
        check("t6_full", {31'd0, bus.mdu_ready}, 32'd0);
        check("t6_pend", {31'd0, bus.rs_pend}, 32'd1);
        #1;
        rst = 1'b1;
        bus.wb_en = 1'b1; bus.wb_idx = 5'd25; bus.wb_dat = 32'h250;
        #1;
        check("t6_rst_wen", {31'd0, bus.rf_wen}, 32'd0);
        check("t6_rst_ready", {31'd0, bus.mdu_ready}, 32'd0);
        check("t6_rst_pend", {30'd0, bus.rs_pend, bus.rt_pend}, 32'd0);
        check("t6_rst_stall", {31'd0, bus.stall_req}, 32'd0);
        cyc();
        rst = 1'b0;
        wb_off();
        smp();
        check("t6_post_ready", {31'd0, bus.mdu_ready}, 32'd1);
        check("t6_post_pend", {30'd0, bus.rs_pend, bus.rt_pend}, 32'd0);
        cyc();
        cyc();
        smp();
        check("t6_no_stale", {31'd0, bus.rf_wen}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
